// File: rtl/move_input_queue_if.sv
// Move request handshake between move_input_queue (master) and the game logic (slave).
interface move_input_queue_if;
  logic       move_valid;
  logic       move_ready;
  logic [1:0] move_dir;
  logic [3:0] move_onehot;

  modport master (output move_valid, output move_dir, output move_onehot, input move_ready);
  modport slave  (input move_valid, input move_dir, input move_onehot, output move_ready);
endinterface

// File: rtl/move_input_queue.sv
// Button levels -> arbitrated move requests -> small FIFO with valid/ready output.
// Define MOVE_REPEAT_EN to add hold-to-repeat; without it only press edges make moves.
module move_input_queue #(
  parameter int DEPTH         = 4,
  parameter int REPEAT_DELAY  = 12500000,
  parameter int REPEAT_PERIOD = 5000000,
  parameter int CNT_W         = 24
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic                     btn_up,
  input  logic                     btn_down,
  input  logic                     btn_left,
  input  logic                     btn_right,
  input  logic                     enable,
  input  logic                     clear_overflow,
  move_input_queue_if.master       mq,
  output logic [$clog2(DEPTH):0]   queue_count,
  output logic                     overflow
);
  localparam int PTR_W = $clog2(DEPTH);

  logic [3:0] btn;
  logic [3:0] btn_prev;
  logic [3:0] press;

  assign btn   = {btn_right, btn_left, btn_down, btn_up};
  assign press = btn & ~btn_prev;

  // Tracks levels even while disabled, so a press held across enable rising is ignored.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) btn_prev <= '0;
    else       btn_prev <= btn;
  end

  logic       press_event;
  logic [1:0] press_dir;

  always_comb begin
    press_event = enable && (press != 4'b0000);
    press_dir   = 2'd0;
    if      (press[0]) press_dir = 2'd0;
    else if (press[1]) press_dir = 2'd1;
    else if (press[2]) press_dir = 2'd2;
    else if (press[3]) press_dir = 2'd3;
  end

  logic       rep_event;
  logic [1:0] rep_dir;

`ifdef MOVE_REPEAT_EN
  localparam logic [1:0] S_IDLE   = 2'd0;
  localparam logic [1:0] S_DELAY  = 2'd1;
  localparam logic [1:0] S_PERIOD = 2'd2;

  logic [1:0]       rep_state;
  logic [CNT_W-1:0] rep_cnt;

  // One repeat engine for the whole block; a fresh press always retargets it.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      rep_state <= S_IDLE;
      rep_cnt   <= '0;
      rep_dir   <= 2'd0;
    end else if (!enable) begin
      rep_state <= S_IDLE;
      rep_cnt   <= '0;
    end else if (press_event) begin
      rep_state <= S_DELAY;
      rep_dir   <= press_dir;
      rep_cnt   <= CNT_W'(REPEAT_DELAY - 1);
    end else if (rep_state != S_IDLE) begin
      if (!btn[rep_dir]) begin
        rep_state <= S_IDLE;
      end else if (rep_cnt == '0) begin
        rep_state <= S_PERIOD;
        rep_cnt   <= CNT_W'(REPEAT_PERIOD - 1);
      end else begin
        rep_cnt <= rep_cnt - 1'b1;
      end
    end
  end

  assign rep_event = enable && (rep_state != S_IDLE) && btn[rep_dir] &&
                     (rep_cnt == '0) && !press_event;
`else
  assign rep_event = 1'b0;
  assign rep_dir   = 2'd0;
`endif

  logic       push_req;
  logic [1:0] event_dir;
  logic       full;
  logic       pop;
  logic       push;

  assign push_req  = press_event || rep_event;
  assign event_dir = press_event ? press_dir : rep_dir;
  assign full      = (queue_count == (PTR_W + 1)'(DEPTH));
  assign pop       = mq.move_valid && mq.move_ready;
  assign push      = push_req && (!full || pop);

  logic [1:0]       mem [DEPTH];
  logic [PTR_W-1:0] wr_ptr;
  logic [PTR_W-1:0] rd_ptr;

  // Storage needs no reset: queue_count gates everything read from it.
  always_ff @(posedge clk) begin
    if (push) mem[wr_ptr] <= event_dir;
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      wr_ptr      <= '0;
      rd_ptr      <= '0;
      queue_count <= '0;
    end else if (!enable) begin
      wr_ptr      <= '0;
      rd_ptr      <= '0;
      queue_count <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + 1'b1;
      if (pop)  rd_ptr <= rd_ptr + 1'b1;
      case ({push, pop})
        2'b10:   queue_count <= queue_count + 1'b1;
        2'b01:   queue_count <= queue_count - 1'b1;
        default: queue_count <= queue_count;
      endcase
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset)                         overflow <= 1'b0;
    else if (clear_overflow)           overflow <= 1'b0;
    else if (push_req && full && !pop) overflow <= 1'b1;
  end

  assign mq.move_valid  = (queue_count != '0);
  assign mq.move_dir    = mq.move_valid ? mem[rd_ptr] : 2'd0;
  assign mq.move_onehot = mq.move_valid ? (4'b0001 << mq.move_dir) : 4'b0000;
endmodule
